// File: rtl/lc3_defs.sv
// Shared LC-3 memory-port definitions: bus/address widths, handshake FSM encoding
// and the poison value returned by a timed-out read.
package lc3_defs;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [15:0] TIMEOUT_POISON = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/lc3_mem_handshake_fsm.sv
// IDLE/BUSY/DONE handshake sequencer: owns the memory request, latched write enable and R.
// Optional watchdog abort is compiled in with LC3_MEM_TIMEOUT_EN.
module lc3_mem_handshake_fsm
    import lc3_defs::*;
`ifdef LC3_MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 15
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mio_en,
    input  logic       r_w,
    input  logic       mem_ready,
    output mem_state_e state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       r_out,
    output logic       rd_capture
`ifdef LC3_MEM_TIMEOUT_EN
   ,output logic       rd_abort,
    output logic       mem_err
`endif
);

    mem_state_e state_q, state_d;
    logic       we_q, we_d;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
`ifdef LC3_MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        rd_capture = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        rd_abort   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mio_en) begin
                    state_d = ST_BUSY;
                    we_d    = r_w;
`ifdef LC3_MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d    = ST_DONE;
                    rd_capture = ~we_q;
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = ST_DONE;
                    err_d    = 1'b1;
                    rd_abort = ~we_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state flop, so an async reset drops them at once.
    assign state   = state_q;
    assign mem_req = (state_q == ST_BUSY);
    assign mem_we  = (state_q == ST_BUSY) & we_q;
    assign r_out   = (state_q == ST_DONE);
`ifdef LC3_MEM_TIMEOUT_EN
    assign mem_err = err_q;
`endif

endmodule

// File: rtl/lc3_bus_mem_port.sv
// LC-3 memory-side bus endpoint: MAR/MDR capture, GateMDR drive and the memory handshake.
// Optional request timeout/abort (mem_err port) is enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_bus_mem_port #(
    parameter int DATA_W = lc3_defs::DATA_W,
    parameter int ADDR_W = lc3_defs::ADDR_W
`ifdef LC3_MEM_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic              gate_mdr,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              r_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef LC3_MEM_TIMEOUT_EN
   ,output logic              mem_err
`endif
);

    import lc3_defs::*;

    mem_state_e        state;
    logic              rd_capture;
    logic [DATA_W-1:0] mar, mdr, rd_buf;
`ifdef LC3_MEM_TIMEOUT_EN
    logic              rd_abort;
`endif

    lc3_mem_handshake_fsm
`ifdef LC3_MEM_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
        u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .mio_en     (mio_en),
            .r_w        (r_w),
            .mem_ready  (mem_ready),
            .state      (state),
            .mem_req    (mem_req),
            .mem_we     (mem_we),
            .r_out      (r_out),
            .rd_capture (rd_capture)
`ifdef LC3_MEM_TIMEOUT_EN
           ,.rd_abort   (rd_abort),
            .mem_err    (mem_err)
`endif
        );

    // MAR/MDR only move while idle (bus loads) or in DONE (read data return); BUSY freezes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_mar)            mar <= bus_in;
                    if (ld_mdr && !mio_en) mdr <= bus_in;
                end
                ST_DONE: begin
                    if (ld_mdr && mio_en && !r_w) mdr <= rd_buf;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_buf <= '0;
        end else if (rd_capture) begin
            rd_buf <= mem_rdata;
        end
`ifdef LC3_MEM_TIMEOUT_EN
        else if (rd_abort) begin
            rd_buf <= DATA_W'(TIMEOUT_POISON);
        end
`endif
    end

    // The tri-state enable must also be released by reset, not only by gate_mdr.
    assign bus_out   = mdr;
    assign bus_oe    = gate_mdr & rst_n;
    assign mem_addr  = mar[ADDR_W-1:0];
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_lc3_bus_mem_port.sv
// Self-checking bench for lc3_bus_mem_port: directed scenarios plus randomized transfers
// against a transaction-level model (register shadows and a sparse memory array).
module tb_lc3_bus_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
    logic [15:0] bus_out;
    logic        bus_oe, r_out;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ready;
`ifdef LC3_MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_mar, exp_mdr;
    logic [15:0] mem_model [logic [15:0]];

    lc3_bus_mem_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .gate_mdr  (gate_mdr),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .r_out     (r_out),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef LC3_MEM_TIMEOUT_EN
       ,.mem_err   (mem_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Idle-time register loads from the bus; stray mem_ready must be ignored here.
    task automatic idle_load(input logic do_mar, input logic [15:0] a,
                             input logic do_mdr, input logic [15:0] d);
        mem_ready = 1'($urandom);
        if (do_mar) begin
            bus_in = a; ld_mar = 1'b1;
            @(negedge clk);
            ld_mar  = 1'b0;
            exp_mar = a;
        end
        if (do_mdr) begin
            bus_in = d; ld_mdr = 1'b1;
            @(negedge clk);
            ld_mdr  = 1'b0;
            exp_mdr = d;
        end
        mem_ready = 1'b0;
        check("idle_addr", mem_addr, exp_mar);
        check("idle_mdr", bus_out, exp_mdr);
        check("idle_req", mem_req, 0);
    endtask

    // One memory transfer starting from an IDLE negedge; returns at the following IDLE negedge.
    task automatic xfer(input logic we, input int waits, input logic with_mar,
                        input logic [15:0] addr, input logic poke);
        logic [15:0] rdata;
        mio_en = 1'b1; r_w = we; ld_mdr = ~we; ld_mar = with_mar;
        bus_in = with_mar ? addr : 16'($urandom);
        if (with_mar) exp_mar = addr;
        rdata = '0;
        if (!we) begin
            if (!mem_model.exists(exp_mar)) mem_model[exp_mar] = 16'($urandom);
            rdata = mem_model[exp_mar];
        end
        for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            check("busy_req", mem_req, 1);
            check("busy_addr", mem_addr, exp_mar);
            check("busy_we", mem_we, we);
            check("busy_rout", r_out, 0);
            if (we) check("busy_wdata", mem_wdata, exp_mdr);
            ld_mar    = poke;
            ld_mdr    = poke | ~we;
            bus_in    = poke ? 16'hFFFF : 16'($urandom);
            mem_ready = (c == waits);
            mem_rdata = (c == waits) ? rdata : 16'($urandom);
        end
        @(negedge clk);
        check("done_rout", r_out, 1);
        check("done_req", mem_req, 0);
        check("done_we", mem_we, 0);
        check("done_addr", mem_addr, exp_mar);
`ifdef LC3_MEM_TIMEOUT_EN
        check("done_err", mem_err, 0);
`endif
        ld_mar    = 1'b0;
        ld_mdr    = ~we;
        mem_ready = 1'($urandom);
        if (we) mem_model[exp_mar] = exp_mdr;
        else    exp_mdr = rdata;
        @(negedge clk);
        check("post_rout", r_out, 0);
        check("post_req", mem_req, 0);
        check("post_mdr", bus_out, exp_mdr);
        check("post_addr", mem_addr, exp_mar);
        mio_en = 1'b0; ld_mdr = 1'b0; mem_ready = 1'b0;
    endtask

    logic rwe;

    initial begin
        rst_n = 1'b0; bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
        r_w = 1'b0; gate_mdr = 1'b1; mem_rdata = '0; mem_ready = 1'b0;
        exp_mar = '0; exp_mdr = '0;

        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_rout", r_out, 0);
        check("rst_oe", bus_oe, 0);
        check("rst_mar", mem_addr, 0);
        check("rst_mdr", bus_out, 0);
`ifdef LC3_MEM_TIMEOUT_EN
        check("rst_err", mem_err, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("oe_on", bus_oe, 1);
        gate_mdr = 1'b0; #1;
        check("oe_off", bus_oe, 0);
        gate_mdr = 1'b1; #1;

        // Read with zero wait states: R two cycles after mio_en, MDR gets memory data.
        mem_model[16'h3000] = 16'h1234;
        idle_load(1'b1, 16'h3000, 1'b0, 16'h0000);
        xfer(1'b0, 0, 1'b0, 16'h0000, 1'b0);
        check("rd_bus_out", bus_out, 16'h1234);
        check("rd_bus_oe", bus_oe, 1);

        // Write with three wait states, bus pokes during BUSY must be ignored.
        idle_load(1'b1, 16'h4000, 1'b1, 16'hBEEF);
        xfer(1'b1, 3, 1'b0, 16'h0000, 1'b1);
        check("wr_mar_kept", mem_addr, 16'h4000);
        check("wr_mdr_kept", bus_out, 16'hBEEF);

        // Back-to-back with MAR loaded on the same edge as mio_en.
        xfer(1'b0, 1, 1'b1, 16'h5000, 1'b0);
        xfer(1'b1, 0, 1'b1, 16'h5002, 1'b0);
        xfer(1'b0, 2, 1'b1, 16'h4000, 1'b0);
        check("b2b_readback", bus_out, 16'hBEEF);

        // Reset in the middle of BUSY drops the request without a clock edge.
        idle_load(1'b1, 16'h7777, 1'b1, 16'hAAAA);
        mio_en = 1'b1; r_w = 1'b1;
        @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_rout", r_out, 0);
        check("mid_rst_oe", bus_oe, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_mar", mem_addr, 0);
        check("mid_rst_mdr", bus_out, 0);
        mio_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; exp_mar = '0; exp_mdr = '0;
        @(negedge clk);

        // Randomized transfers against the model.
        for (int i = 0; i < 30; i++) begin
            rwe = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                xfer(rwe, $urandom_range(0, 4), 1'b1, 16'($urandom), 1'($urandom));
            end else begin
                idle_load(1'($urandom), 16'($urandom), rwe, 16'($urandom));
                xfer(rwe, $urandom_range(0, 4), 1'b0, 16'h0000, 1'($urandom));
            end
        end

`ifdef LC3_MEM_TIMEOUT_EN
        // Read that memory never acknowledges: abort after 15 BUSY cycles with poison data.
        idle_load(1'b1, 16'h6000, 1'b0, 16'h0000);
        mio_en = 1'b1; r_w = 1'b0; ld_mdr = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("to_req", mem_req, 1);
            check("to_err_busy", mem_err, 0);
            mem_ready = 1'b0;
        end
        @(negedge clk);
        check("to_rout", r_out, 1);
        check("to_err", mem_err, 1);
        check("to_req_drop", mem_req, 0);
        @(negedge clk);
        check("to_err_clr", mem_err, 0);
        check("to_rout_clr", r_out, 0);
        check("to_poison", bus_out, 16'hDEAD);
        mio_en = 1'b0; ld_mdr = 1'b0;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
